// File: rtl/mp7_scan_ctrl_if.sv
// Sample output stream of the scan controller.
// master: drives data_out/data_ch/data_valid, receives data_ready.
// slave : consumer side of the same handshake.
interface mp7_scan_ctrl_if #(
  parameter int unsigned WIDTH = 7
);
  logic [WIDTH-1:0] data_out;
  logic [2:0]       data_ch;
  logic             data_valid;
  logic             data_ready;

  modport master (output data_out, data_ch, data_valid, input data_ready);
  modport slave  (input data_out, data_ch, data_valid, output data_ready);
endinterface

// File: rtl/mp7_scan_ctrl.sv
// Round-robin scan controller for a NCH-to-1 mux: steps sel through the
// enabled channels, waits DWELL settle cycles on each, captures mux_out and
// presents it downstream on a valid/ready stream.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start, stop  one-cycle scan start / abort pulses
//   ch_mask      channel enables (bit i = channel i)
//   mux_out      mux data for the current sel
//   sel          mux select
//   busy         high whenever the controller is not idle
//   drop_cnt     overwritten samples (only counts with MP_SCAN_DROP_EN)
//   dout         sample stream (data_out, data_ch, data_valid, data_ready)
// Build option: define MP_SCAN_DROP_EN to never stall; unconsumed samples are
// overwritten and counted in drop_cnt (saturating). Undefined: stall, drop_cnt=0.
module mp7_scan_ctrl #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned NCH   = 7,
  parameter int unsigned DWELL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [NCH-1:0]   ch_mask,
  input  logic [WIDTH-1:0] mux_out,
  output logic [2:0]       sel,
  output logic             busy,
  output logic [7:0]       drop_cnt,
  mp7_scan_ctrl_if.master  dout
);

  localparam int unsigned SELW = 3;
  localparam int unsigned CNTW = 8;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SELW-1:0]   ch_q, ch_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
`ifdef MP_SCAN_DROP_EN
  logic [7:0]        drop_q, drop_d;
`endif

  logic [7:0]        mask8;
  logic              any_en;
  logic [SELW-1:0]   first_ch;
  logic [SELW-1:0]   next_ch;
  logic              found;
  logic [3:0]        idx;
  logic              free;
  logic              capture;

  assign mask8  = 8'(ch_mask);
  assign any_en = |ch_mask;
  assign free   = !valid_q || dout.data_ready;

  // Lowest enabled channel, and first enabled channel strictly above sel
  // (wrapping; falls back to sel itself when it is the only one enabled).
  always_comb begin
    first_ch = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask8[i]) first_ch = SELW'(i);
    end
    next_ch = sel_q;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= int'(NCH); k++) begin
      idx = {1'b0, sel_q} + 4'(k);
      if (idx >= 4'(NCH)) idx = idx - 4'(NCH);
      if (!found && mask8[idx[2:0]]) begin
        next_ch = idx[2:0];
        found   = 1'b1;
      end
    end
  end

  // Capture condition; stop always wins over a same-cycle capture.
`ifdef MP_SCAN_DROP_EN
  assign capture = (state_q == S_SAMPLE) && !stop;
`else
  assign capture = (state_q == S_SAMPLE) && !stop && free;
`endif

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MP_SCAN_DROP_EN
      drop_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef MP_SCAN_DROP_EN
      drop_q  <= drop_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && any_en) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (stop)                state_d = S_IDLE;
        else if (cnt_q == '0)    state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (stop)                state_d = S_IDLE;
        else if (capture)        state_d = any_en ? S_SETTLE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and dwell counter.
  always_comb begin
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q && !dout.data_ready;
    busy_d  = (state_d != S_IDLE);
`ifdef MP_SCAN_DROP_EN
    drop_d  = drop_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && any_en) begin
          sel_d = first_ch;
          cnt_d = CNT_LOAD;
        end
      end
      S_SETTLE: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNTW'(1);
      end
      S_SAMPLE: begin
        if (capture) begin
          data_d  = mux_out;
          ch_d    = sel_q;
          valid_d = 1'b1;
          cnt_d   = CNT_LOAD;
          if (any_en) sel_d = next_ch;
`ifdef MP_SCAN_DROP_EN
          if (!free && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
`endif
        end
      end
      default: ;
    endcase
  end

  assign sel             = sel_q;
  assign busy            = busy_q;
  assign dout.data_out   = data_q;
  assign dout.data_ch    = ch_q;
  assign dout.data_valid = valid_q;
`ifdef MP_SCAN_DROP_EN
  assign drop_cnt        = drop_q;
`else
  assign drop_cnt        = 8'd0;
`endif

endmodule

// File: tb/tb_mp7_scan_ctrl.sv
// Testbench for mp7_scan_ctrl: scenario tasks with a channel-order /
// timing reference model built from the enabled-channel list.
module tb_mp7_scan_ctrl;
  localparam int unsigned WIDTH  = 7;
  localparam int unsigned NCH    = 7;
  localparam int unsigned DWELL  = 4;
  localparam int          PERIOD = int'(DWELL) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [NCH-1:0]   ch_mask = '0;
  logic [WIDTH-1:0] mux_out;
  logic [2:0]       sel;
  logic             busy;
  logic [7:0]       drop_cnt;
  logic [WIDTH-1:0] mux_tbl [8];
  int               en_list [$];
  int               checks = 0;
  int               errors = 0;

  mp7_scan_ctrl_if #(.WIDTH(WIDTH)) dif ();

  mp7_scan_ctrl #(.WIDTH(WIDTH), .NCH(NCH), .DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ch_mask(ch_mask),
    .mux_out(mux_out), .sel(sel), .busy(busy), .drop_cnt(drop_cnt), .dout(dif)
  );

  always #5 clk = ~clk;

  // Downstream mux model.
  always_comb mux_out = mux_tbl[sel];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Enabled channels in ascending order: the scan visits them cyclically.
  task automatic build_list(input logic [NCH-1:0] mask);
    en_list.delete();
    for (int i = 0; i < int'(NCH); i++) if (mask[i]) en_list.push_back(i);
  endtask

  task automatic go_idle();
    stop = 1'b1; tick(); stop = 1'b0;
    dif.data_ready = 1'b1; tick(); tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick();
    checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d want 0", sel); end
    checks++; if (dif.data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dif.data_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    checks++; if (dif.data_out !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", dif.data_out); end
    checks++; if (dif.data_ch !== 3'd0) begin errors++; $display("FAIL reset_ch: got %0d want 0", dif.data_ch); end
    rst_n = 1'b1; tick();
  endtask

  // Free-running scan with data_ready=1: checks timing, order, data and sel.
  task automatic test_scan(input logic [NCH-1:0] mask, input int nsamp,
                           input bit fixed_tbl, input string name);
    int cyc;
    int k;
    logic [2:0] exp_ch;
    logic [2:0] exp_sel;
    build_list(mask);
    for (int i = 0; i < 8; i++)
      mux_tbl[i] = fixed_tbl ? WIDTH'(7'h10 + i) : WIDTH'($urandom);
    ch_mask = mask; dif.data_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    cyc = 0; k = 0;
    while (cyc < PERIOD * (nsamp + 2) && k < nsamp) begin
      tick(); cyc++; start = 1'b0;
      if (dif.data_valid) begin
        exp_ch  = 3'(en_list[k % en_list.size()]);
        exp_sel = 3'(en_list[(k + 1) % en_list.size()]);
        checks++; if (cyc != PERIOD * (k + 1)) begin errors++; $display("FAIL %s_time%0d: got cycle %0d want %0d", name, k, cyc, PERIOD * (k + 1)); end
        checks++; if (dif.data_ch !== exp_ch) begin errors++; $display("FAIL %s_ch%0d: got %0d want %0d", name, k, dif.data_ch, exp_ch); end
        checks++; if (dif.data_out !== mux_tbl[exp_ch]) begin errors++; $display("FAIL %s_data%0d: got %h want %h", name, k, dif.data_out, mux_tbl[exp_ch]); end
        checks++; if (sel !== exp_sel) begin errors++; $display("FAIL %s_sel%0d: got %0d want %0d", name, k, sel, exp_sel); end
        k++;
        if (k == 3) start = 1'b1;  // start while busy must be ignored
      end
    end
    start = 1'b0;
    checks++; if (k != nsamp) begin errors++; $display("FAIL %s_count: got %0d want %0d", name, k, nsamp); end
    stop = 1'b1; tick(); stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_stop_busy: got %b want 0", name, busy); end
    tick(); tick();
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] old_v;
    logic [WIDTH-1:0] new_v;
    for (int i = 0; i < 8; i++) mux_tbl[i] = WIDTH'($urandom);
    old_v = mux_tbl[2];
    new_v = ~old_v;
    ch_mask = 7'b0000100; dif.data_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 20 && !dif.data_valid; i++) tick();
    checks++; if (dif.data_valid !== 1'b1 || dif.data_out !== old_v) begin errors++; $display("FAIL stall_first: got valid %b data %h want 1 %h", dif.data_valid, dif.data_out, old_v); end
    mux_tbl[2] = new_v;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (dif.data_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", dif.data_valid); end
    checks++; if (sel !== 3'd2) begin errors++; $display("FAIL stall_sel: got %0d want 2", sel); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b want 1", busy); end
    checks++; if (dif.data_ch !== 3'd2) begin errors++; $display("FAIL stall_ch: got %0d want 2", dif.data_ch); end
`ifdef MP_SCAN_DROP_EN
    checks++; if (drop_cnt !== 8'd3) begin errors++; $display("FAIL stall_drop: got %0d want 3", drop_cnt); end
    checks++; if (dif.data_out !== new_v) begin errors++; $display("FAIL stall_data: got %h want %h", dif.data_out, new_v); end
`else
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL stall_drop: got %0d want 0", drop_cnt); end
    checks++; if (dif.data_out !== old_v) begin errors++; $display("FAIL stall_data: got %h want %h", dif.data_out, old_v); end
    // Resume: a new capture on the first edge, then one sample per PERIOD.
    dif.data_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++; if (dif.data_valid !== ((k % PERIOD) == 1)) begin errors++; $display("FAIL resume_valid%0d: got %b want %b", k, dif.data_valid, (k % PERIOD) == 1); end
      if (k == 1) begin
        checks++; if (dif.data_out !== new_v) begin errors++; $display("FAIL resume_data: got %h want %h", dif.data_out, new_v); end
      end
    end
`endif
    go_idle();
  endtask

  task automatic test_stop();
    int seen3;
    bit any_busy;
    bit got;
    for (int i = 0; i < 8; i++) mux_tbl[i] = WIDTH'($urandom);
    ch_mask = 7'h7F; dif.data_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      got = dif.data_valid && dif.data_ch == 3'd2;
    end
    checks++; if (!got) begin errors++; $display("FAIL stop_wait_ch2: got no ch2 sample want one"); end
    tick(); tick();
    stop = 1'b1; tick(); stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b want 0", busy); end
    seen3 = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (dif.data_valid && dif.data_ch == 3'd3) seen3++;
    end
    checks++; if (seen3 != 0) begin errors++; $display("FAIL stop_no_ch3: got %0d samples want 0", seen3); end
    ch_mask = '0;
    start = 1'b1; tick(); start = 1'b0;
    any_busy = busy;
    for (int i = 0; i < 5; i++) begin tick(); any_busy |= busy; end
    checks++; if (any_busy) begin errors++; $display("FAIL zero_mask_start: got busy 1 want 0"); end
  endtask

  task automatic test_mask_clear();
    bit got;
    for (int i = 0; i < 8; i++) mux_tbl[i] = WIDTH'($urandom);
    ch_mask = 7'h7F; dif.data_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = dif.data_valid && dif.data_ch == 3'd0;
    end
    checks++; if (!got) begin errors++; $display("FAIL clr_wait_ch0: got no ch0 sample want one"); end
    ch_mask = '0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = dif.data_valid;
    end
    checks++; if (!got || dif.data_ch !== 3'd1) begin errors++; $display("FAIL clr_ch: got valid %b ch %0d want 1 1", got, dif.data_ch); end
    checks++; if (dif.data_out !== mux_tbl[1]) begin errors++; $display("FAIL clr_data: got %h want %h", dif.data_out, mux_tbl[1]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b want 0", busy); end
    checks++; if (sel !== 3'd1) begin errors++; $display("FAIL clr_sel: got %0d want 1", sel); end
    tick(); tick();
    checks++; if (busy !== 1'b0 || dif.data_valid !== 1'b0) begin errors++; $display("FAIL clr_idle: got busy %b valid %b want 0 0", busy, dif.data_valid); end
  endtask

  // Random mask, random back-pressure and stray start pulses.
  task automatic test_random();
    logic [NCH-1:0]   mask;
    logic [2:0]       exp_ch;
    logic [WIDTH-1:0] prev_d;
    logic [2:0]       prev_c;
    bit               prev_hold;
    int               hs;
    mask = NCH'($urandom_range(1, (1 << NCH) - 1));
    build_list(mask);
    for (int i = 0; i < 8; i++) mux_tbl[i] = WIDTH'($urandom);
    ch_mask = mask; dif.data_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    hs = 0; prev_hold = 1'b0; prev_d = '0; prev_c = '0;
    for (int c = 0; c < 400; c++) begin
      tick();
`ifndef MP_SCAN_DROP_EN
      if (prev_hold) begin
        checks++; if (dif.data_valid !== 1'b1 || dif.data_out !== prev_d || dif.data_ch !== prev_c) begin errors++; $display("FAIL rnd_hold%0d: got %b %h %0d want 1 %h %0d", c, dif.data_valid, dif.data_out, dif.data_ch, prev_d, prev_c); end
      end
`endif
      dif.data_ready = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 15) == 0);
      if (dif.data_valid && dif.data_ready) begin
`ifdef MP_SCAN_DROP_EN
        exp_ch = dif.data_ch;
        checks++; if (!mask[dif.data_ch]) begin errors++; $display("FAIL rnd_ch%0d: got disabled ch %0d", hs, dif.data_ch); end
`else
        exp_ch = 3'(en_list[hs % en_list.size()]);
        checks++; if (dif.data_ch !== exp_ch) begin errors++; $display("FAIL rnd_ch%0d: got %0d want %0d", hs, dif.data_ch, exp_ch); end
`endif
        checks++; if (dif.data_out !== mux_tbl[exp_ch]) begin errors++; $display("FAIL rnd_data%0d: got %h want %h", hs, dif.data_out, mux_tbl[exp_ch]); end
        hs++;
      end
      prev_hold = dif.data_valid && !dif.data_ready;
      prev_d = dif.data_out; prev_c = dif.data_ch;
    end
    start = 1'b0;
    checks++; if (hs < 20) begin errors++; $display("FAIL rnd_throughput: got %0d samples want >= 20", hs); end
    go_idle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) mux_tbl[i] = WIDTH'($urandom);
    ch_mask = 7'h7F; dif.data_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < int'($urandom_range(8, 30)); i++) tick();
    rst_n = 1'b0; tick();
    checks++; if (busy !== 1'b0 || dif.data_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_state: got busy %b valid %b want 0 0", busy, dif.data_valid); end
    checks++; if (sel !== 3'd0 || dif.data_ch !== 3'd0 || dif.data_out !== '0) begin errors++; $display("FAIL mid_rst_regs: got sel %0d ch %0d data %h want 0 0 0", sel, dif.data_ch, dif.data_out); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst_drop: got %0d want 0", drop_cnt); end
    rst_n = 1'b1; dif.data_ready = 1'b1; tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_after: got busy %b want 0", busy); end
  endtask

  initial begin
    dif.data_ready = 1'b0;
    for (int i = 0; i < 8; i++) mux_tbl[i] = '0;
    test_reset();
    test_scan(7'h7F, 8, 1'b1, "full");
    test_scan(7'b0100101, 5, 1'b0, "sparse");
    test_stall();
    test_stop();
    test_mask_clear();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
